// File: rtl/obi_shim_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : obi_shim_pkg
//  Description : Shared types and constants for the OBI latency shim.
//                - mode_e: delay mode (passthrough, fixed, pseudo-random)
//                - state_e: request-side FSM states
//                - LFSR_TAPS / lfsr_next: 16-bit Galois LFSR,
//                  polynomial x^16+x^14+x^13+x^11+1
//  Revision    : 1.0 - initial release
// ============================================================================
package obi_shim_pkg;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_FIXED = 2'd1,
        MODE_RAND  = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        FWD  = 2'd2
    } state_e;

    // Right-shifting Galois form: bit 15 <- x^16, bits 13/12/10 <- x^14/x^13/x^11
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage : obi_shim_pkg
`default_nettype wire

// File: rtl/obi_shim_resp_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : obi_shim_resp_fifo
//  Description : In-order response FIFO. Each entry carries a countdown that
//                decrements every cycle (saturating at 0). Only the head may
//                leave, and only once its own countdown is 0, so a younger
//                entry that has already expired still waits behind the head.
//  Ports       : clk_i/rst_ni      clock, async active-low reset
//                push_i/push_*_i   write data + countdown at the tail
//                pop_i             remove the head (ignored unless ready)
//                empty_o           no entries held
//                head_ready_o      head present and its countdown is 0
//                head_data_o       data of the head entry
//  Revision    : 1.0 - initial release
// ============================================================================
module obi_shim_resp_fifo #(
    parameter int DEPTH      = 2,
    parameter int DATA_WIDTH = 32,
    parameter int DLY_WIDTH  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic [DLY_WIDTH-1:0]  push_dly_i,
    input  logic                  pop_i,
    output logic                  empty_o,
    output logic                  head_ready_o,
    output logic [DATA_WIDTH-1:0] head_data_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DLY_WIDTH-1:0]  dly_q  [DEPTH];
    logic [PW-1:0]         rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]         count_q;
    logic                  w_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty_o      = (count_q == '0);
    assign head_ready_o = !empty_o && (dly_q[rd_ptr_q] == '0);
    assign head_data_o  = data_q[rd_ptr_q];
    assign w_pop        = pop_i && head_ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                dly_q[i]  <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // Age every slot; stale slots are harmless since they are rewritten on push.
            for (int i = 0; i < DEPTH; i++) begin
                if (dly_q[i] != '0) begin
                    dly_q[i] <= dly_q[i] - DLY_WIDTH'(1);
                end
            end
            if (push_i) begin
                data_q[wr_ptr_q] <= push_data_i;
                dly_q[wr_ptr_q]  <= push_dly_i;
                wr_ptr_q         <= ptr_inc(wr_ptr_q);
            end
            if (w_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q <= count_q + CW'(push_i) - CW'(w_pop);
        end
    end

    a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push_i && !w_pop && (count_q == CW'(DEPTH))));

endmodule : obi_shim_resp_fifo
`default_nettype wire

// File: rtl/obi_latency_shim.sv
`default_nettype none
// ============================================================================
//  Module      : obi_latency_shim
//  Description : OBI slave-to-master shim that injects grant stalls and
//                response latency (fixed or LFSR-random), limits the number
//                of outstanding transactions and keeps responses in order.
//  Ports       : clk_i, rst_ni                 clock, async active-low reset
//                mode_i                        0 pass, 1 fixed, 2 random, 3=0
//                gnt_dly_i, rvalid_dly_i       delay values / random bounds
//                req_i..wdata_i, gnt_o         upstream request channel
//                rvalid_o, rdata_o             upstream response channel
//                req_o..wdata_o, gnt_i         downstream request channel
//                rvalid_i, rdata_i             downstream response channel
//                outstanding_o                 granted-but-unanswered count
//  Revision    : 1.0 - initial release
// ============================================================================
module obi_latency_shim
    import obi_shim_pkg::*;
#(
    parameter int          DATA_WIDTH      = 32,
    parameter int          ADDR_WIDTH      = 32,
    parameter int          MAX_OUTSTANDING = 2,
    parameter int          DLY_WIDTH       = 4,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [1:0]                           mode_i,
    input  logic [DLY_WIDTH-1:0]                 gnt_dly_i,
    input  logic [DLY_WIDTH-1:0]                 rvalid_dly_i,
    input  logic                                 req_i,
    output logic                                 gnt_o,
    input  logic [ADDR_WIDTH-1:0]                addr_i,
    input  logic                                 we_i,
    input  logic [DATA_WIDTH/8-1:0]              be_i,
    input  logic [DATA_WIDTH-1:0]                wdata_i,
    output logic                                 rvalid_o,
    output logic [DATA_WIDTH-1:0]                rdata_o,
    output logic                                 req_o,
    input  logic                                 gnt_i,
    output logic [ADDR_WIDTH-1:0]                addr_o,
    output logic                                 we_o,
    output logic [DATA_WIDTH/8-1:0]              be_o,
    output logic [DATA_WIDTH-1:0]                wdata_o,
    input  logic                                 rvalid_i,
    input  logic [DATA_WIDTH-1:0]                rdata_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    state_e               state_q, state_d;
    mode_e                mode_q, mode_d;
    logic [DLY_WIDTH-1:0] cnt_q, cnt_d;
    logic [OW-1:0]        outstanding_q, outstanding_d;
    logic [15:0]          lfsr_q, lfsr_d;

    logic                 w_room, w_req, w_quiet;
    logic [DLY_WIDTH-1:0] w_gdly, w_rdly, w_push_dly;
    logic                 w_fifo_empty, w_head_ready;
    logic [DATA_WIDTH-1:0] w_head_data;
    logic                 w_bypass, w_push, w_bypass_valid;

    function automatic logic [DLY_WIDTH-1:0] sel_delay(input mode_e m,
                                                       input logic [DLY_WIDTH-1:0] cfg,
                                                       input logic [DLY_WIDTH-1:0] rnd);
        case (m)
            MODE_FIXED: return cfg;
            MODE_RAND:  return (rnd < cfg) ? rnd : cfg;
            default:    return '0;
        endcase
    endfunction

    assign addr_o  = addr_i;
    assign we_o    = we_i;
    assign be_o    = be_i;
    assign wdata_o = wdata_i;

    assign w_room  = (outstanding_q < OW'(MAX_OUTSTANDING));
    assign w_gdly  = sel_delay(mode_q, gnt_dly_i, lfsr_q[DLY_WIDTH-1:0]);
    assign w_rdly  = sel_delay(mode_q, rvalid_dly_i, lfsr_q[DLY_WIDTH-1:0]);
    assign lfsr_d  = lfsr_next(lfsr_q);

    // The request arrival cycle counts as the first stall cycle, so WAIT only
    // covers d-1 cycles and gnt_o can rise exactly d cycles after req_i.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        w_req   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    if (w_gdly == '0) begin
                        w_req   = w_room;
                        state_d = FWD;
                    end else if (w_gdly == DLY_WIDTH'(1)) begin
                        state_d = FWD;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = w_gdly - DLY_WIDTH'(1);
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - DLY_WIDTH'(1);
                if (cnt_q == DLY_WIDTH'(1)) begin
                    state_d = FWD;
                end
            end
            FWD: begin
                w_req = w_room;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (w_req && gnt_i) begin
            state_d = IDLE;
        end
    end

    // Combinational outputs are gated by rst_ni so they drop with the reset
    // itself, not just with the registers.
    assign req_o = w_req && rst_ni;
    assign gnt_o = req_o && gnt_i;

    // Response path. A response with nothing outstanding (e.g. a leftover from
    // before a reset) is dropped rather than forwarded.
    assign w_bypass       = w_fifo_empty && (w_rdly == '0);
    assign w_push         = rvalid_i && !w_bypass && (outstanding_q != '0);
    assign w_bypass_valid = rvalid_i && w_bypass && (outstanding_q != '0);
    // Countdown is stored one short: the push cycle itself is the first cycle of delay.
    assign w_push_dly     = (w_rdly == '0) ? '0 : w_rdly - DLY_WIDTH'(1);

    obi_shim_resp_fifo #(
        .DEPTH      (MAX_OUTSTANDING),
        .DATA_WIDTH (DATA_WIDTH),
        .DLY_WIDTH  (DLY_WIDTH)
    ) u_resp_fifo (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .push_i       (w_push),
        .push_data_i  (rdata_i),
        .push_dly_i   (w_push_dly),
        .pop_i        (w_head_ready),
        .empty_o      (w_fifo_empty),
        .head_ready_o (w_head_ready),
        .head_data_o  (w_head_data)
    );

    always_comb begin
        rvalid_o = 1'b0;
        rdata_o  = '0;
        if (rst_ni) begin
            if (w_bypass_valid) begin
                rvalid_o = 1'b1;
                rdata_o  = rdata_i;
            end else if (w_head_ready) begin
                rvalid_o = 1'b1;
                rdata_o  = w_head_data;
            end
        end
    end

    assign outstanding_d = outstanding_q + OW'(gnt_o) - OW'(rvalid_o);
    assign outstanding_o = outstanding_q;

    // Mode only changes while the channel is fully quiet so in-flight
    // transactions keep the timing they started with.
    assign w_quiet = (outstanding_q == '0) && w_fifo_empty && (state_q == IDLE);

    always_comb begin
        mode_d = mode_q;
        if (w_quiet) begin
            case (mode_i)
                2'd1:    mode_d = MODE_FIXED;
                2'd2:    mode_d = MODE_RAND;
                default: mode_d = MODE_PASS;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            mode_q        <= MODE_PASS;
            cnt_q         <= '0;
            outstanding_q <= '0;
            lfsr_q        <= LFSR_SEED;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            cnt_q         <= cnt_d;
            outstanding_q <= outstanding_d;
            lfsr_q        <= lfsr_d;
        end
    end

    a_rvalid_needs_outstanding : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(rvalid_i && (outstanding_q == '0)));

endmodule : obi_latency_shim
`default_nettype wire
